cmd_line_parser: RTL and testbench
==================================

# cmd_line_parser

Receive-side counterpart of the message ROM. The block assembles bytes from the UART receiver into a command line and, on carriage return, matches the line against the command set. It then issues a sequence of message IDs (command result followed by the shell prompt) to the transmit path, which renders each ID as a string. After reset it first issues the start banner and a prompt.

## Interface
Parameters:
- MAX_LEN, 16: line buffer depth in characters (2..32).

Ports:
- clk  input  1  system clock; the block uses one clock.
- rst  input  1  reset; synchronous, active-high.
- rx_data  input  8  received byte; valid only when rx_valid is high.
- rx_valid  input  1  single-cycle strobe from the UART receiver, one per byte.
- msg_id  output  2  message to transmit: 0 START, 1 SHELL, 2 ERROR, 3 PONG.
- msg_valid  output  1  msg_id is valid; held high until accepted.
- msg_ready  input  1  transmit path accepts msg_id on a cycle where msg_valid && msg_ready.
- busy  output  1  high when the block is not collecting; bytes strobed while busy are dropped.

## Operation
- States: BOOT, SEND_START, SEND_PROMPT, COLLECT, MATCH, SEND_RESULT.
- Reset enters BOOT. Reset values: msg_valid=0, msg_id=0, busy=1, line count=0, overflow flag=0.
- BOOT → SEND_START unconditionally after 1 cycle.
- SEND_START: msg_valid=1, msg_id=0. On handshake → SEND_PROMPT.
- SEND_PROMPT: msg_valid=1, msg_id=1. On handshake → COLLECT, with count and overflow cleared.
- COLLECT (busy=0). Each byte with rx_valid=1 is handled as follows:
  - 0x0D (CR) → MATCH.
  - 0x0A (LF) ignored.
  - 0x08 or 0x7F (backspace): count decrements if count>0, else no effect. The overflow flag is not cleared.
  - Any other byte: if count<MAX_LEN, store it at buffer[count] and increment count; otherwise discard the byte and set the overflow flag.
- MATCH (1 cycle) decides the next state:
  - count==0 and overflow=0 → SEND_PROMPT, with no result message.
  - overflow=1 → SEND_RESULT with ERROR.
  - count==4 and buffer=="PING" (0x50,0x49,0x4E,0x47; exact, case-sensitive) → SEND_RESULT with PONG.
  - Anything else → SEND_RESULT with ERROR.
- SEND_RESULT: msg_valid=1, msg_id=3 (PONG) or 2 (ERROR). On handshake → SEND_PROMPT.
- msg_id stays stable while msg_valid=1. msg_valid=0 in BOOT, COLLECT and MATCH.
- busy=1 in every state except COLLECT. rx bytes arriving while busy=1 are discarded, with no state change and no buffering.
- Buffer contents are not cleared. Only count and the overflow flag reset per line.

## Timing
- Outputs are decoded from the registered state; there is no combinational path from rx_* or msg_ready to any output.
- A CR strobed in cycle N in COLLECT gives: state MATCH in N+1; msg_valid=1 with the result ID in N+2.
- For an empty line, msg_valid=1 with SHELL appears in N+2.
- Handshake in cycle M (msg_valid && msg_ready at the rising edge):
  - The next state is entered in M+1.
  - SEND_RESULT→SEND_PROMPT gives msg_valid=1 continuously, and msg_id changes in M+1.
  - SEND_PROMPT→COLLECT gives msg_valid=0 and busy=0 in M+1. A byte strobed in M+1 is accepted.
- If msg_ready is held high, each message occupies exactly 1 cycle.
- With msg_ready=0, SEND_* states hold indefinitely with outputs stable.
- After rst deasserts: BOOT for 1 cycle, then msg_valid=1 with msg_id=0.
- rst asserted in any state, including mid-line or mid-handshake, returns to BOOT on the next edge. The pending message is abandoned, and the line count and overflow flag clear.
- Count width is clog2(MAX_LEN+1) bits. The count never wraps: increments saturate by discard at MAX_LEN, and decrements stop at 0.

## Test plan
- Reset then msg_ready=1 → msg_id sequence 0,1 on consecutive handshakes, then busy=0.
- Strobe "PING",0x0D → exactly one PONG (3) then one SHELL (1). busy returns to 0; no other messages.
- Strobe "PINGX",0x0D; then "ping",0x0D; then "PINX",0x08,"G",0x0A,0x0D:
  - First two lines → ERROR(2),SHELL(1) each.
  - Third line → PONG(3),SHELL(1), since the backspace is honoured and LF is ignored.
- Strobe 17 'A' bytes then 3 backspaces then 0x0D with MAX_LEN=16 → ERROR(2),SHELL(1), since overflow persists. A bare 0x0D then → SHELL(1) only.
- Hold msg_ready=0 for 10 cycles during SEND_RESULT while strobing "PING",0x0D:
  - msg_id=3 stays stable and busy=1.
  - The strobed bytes are dropped; after release the next line starts from count 0.
- Assert rst for 1 cycle after "PI" while in COLLECT → BOOT, then START(0),SHELL(1). A subsequent "NG",0x0D → ERROR(2),SHELL(1).

Source files
------------

// File: rtl/cmd_line_parser.sv
// Command-line receiver: collects UART bytes into a line buffer, matches "PING" on CR,
// and issues message IDs (result, then prompt) to the transmit path.
module cmd_line_parser #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] msg_id,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic       busy
);

    localparam int CW    = $clog2(MAX_LEN + 1);
    // Deep enough for the four constant-index reads in the PING compare.
    localparam int DEPTH = (MAX_LEN < 4) ? 4 : MAX_LEN;

    typedef enum logic [2:0] {
        BOOT,
        SEND_START,
        SEND_PROMPT,
        COLLECT,
        MATCH,
        SEND_RESULT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic          overflow, overflow_n;
    logic          pong, pong_n;
    logic          wr_en;
    logic          is_ping;
    logic          handshake;
    logic [7:0]    line_buf [DEPTH];

    assign handshake = msg_valid && msg_ready;

    always_comb begin
        is_ping = (int'(count) == 4) &&
                  (line_buf[0] == 8'h50) && (line_buf[1] == 8'h49) &&
                  (line_buf[2] == 8'h4E) && (line_buf[3] == 8'h47);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            count    <= '0;
            overflow <= 1'b0;
            pong     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            overflow <= overflow_n;
            pong     <= pong_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (count == CW'(i)) begin
                    line_buf[i] <= rx_data;
                end
            end
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        overflow_n = overflow;
        pong_n     = pong;
        wr_en      = 1'b0;
        case (state)
            BOOT:       state_n = SEND_START;
            SEND_START: if (handshake) state_n = SEND_PROMPT;
            SEND_PROMPT: begin
                if (handshake) begin
                    state_n    = COLLECT;
                    count_n    = '0;
                    overflow_n = 1'b0;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h0D: state_n = MATCH;
                        8'h0A: ;
                        8'h08, 8'h7F: begin
                            if (count != '0) count_n = count - CW'(1);
                        end
                        default: begin
                            if (int'(count) < MAX_LEN) begin
                                wr_en   = 1'b1;
                                count_n = count + CW'(1);
                            end else begin
                                overflow_n = 1'b1;
                            end
                        end
                    endcase
                end
            end
            MATCH: begin
                if ((count == '0) && !overflow) begin
                    state_n = SEND_PROMPT;
                end else begin
                    state_n = SEND_RESULT;
                    pong_n  = !overflow && is_ping;
                end
            end
            SEND_RESULT: if (handshake) state_n = SEND_PROMPT;
            default:     state_n = BOOT;
        endcase
    end

    always_comb begin
        msg_valid = 1'b0;
        msg_id    = 2'd0;
        busy      = (state != COLLECT);
        case (state)
            SEND_START: begin
                msg_valid = 1'b1;
                msg_id    = 2'd0;
            end
            SEND_PROMPT: begin
                msg_valid = 1'b1;
                msg_id    = 2'd1;
            end
            SEND_RESULT: begin
                msg_valid = 1'b1;
                msg_id    = pong ? 2'd3 : 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cmd_line_parser.sv
// Self-checking bench for cmd_line_parser: vector table, corner-case sequences,
// and random lines checked against a queue-based line model.
module tb_cmd_line_parser;

    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       msg_ready = 1'b1;
    logic [1:0] msg_id;
    logic       msg_valid;
    logic       busy;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    cmd_line_parser #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .msg_id    (msg_id),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .busy      (busy)
    );

    typedef struct {
        logic [319:0] b;
        int           len;
        int           n;
        int           e0;
        int           e1;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Drains messages until the block is collecting again; rnd randomizes msg_ready.
    task automatic collect(input bit rnd, output int n, output int id0, output int id1,
                           output int first_v, output int total);
        int  last_id;
        bit  held;
        n = 0; id0 = 0; id1 = 0; first_v = -1; total = -1;
        held = 1'b0; last_id = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (held) begin
                chk("stall.valid", int'(msg_valid), 1);
                chk("stall.id", int'(msg_id), last_id);
            end
            if (!busy) begin
                total = c;
                break;
            end
            msg_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (msg_valid && first_v < 0) first_v = c;
            held    = msg_valid && !msg_ready;
            last_id = int'(msg_id);
            if (msg_valid && msg_ready) begin
                if (n == 0) id0 = int'(msg_id);
                else if (n == 1) id1 = int'(msg_id);
                n++;
            end
        end
        msg_ready = 1'b1;
    endtask

    task automatic line_check(input string tag, input bit rnd, input int fv,
                              input int en, input int ee0, input int ee1);
        int n, a0, a1, first_v, total;
        collect(rnd, n, a0, a1, first_v, total);
        chk({tag, ".done"}, int'(total >= 0), 1);
        chk({tag, ".nmsg"}, n, en);
        chk({tag, ".msg0"}, a0, ee0);
        if (en == 2) chk({tag, ".msg1"}, a1, ee1);
        if (!rnd) begin
            chk({tag, ".first_valid"}, first_v, fv);
            chk({tag, ".cycles"}, total, fv + en);
        end
        chk({tag, ".idle_valid"}, int'(msg_valid), 0);
    endtask

    task automatic model(input logic [7:0] q[$], output int n, output int e0, output int e1);
        logic [7:0] ln[$];
        bit ovf;
        ovf = 1'b0;
        ln.delete();
        foreach (q[i]) begin
            if (q[i] == 8'h0D) break;
            else if (q[i] == 8'h0A) ;
            else if (q[i] == 8'h08 || q[i] == 8'h7F) begin
                if (ln.size() > 0) void'(ln.pop_back());
            end else if (ln.size() < MAX_LEN) ln.push_back(q[i]);
            else ovf = 1'b1;
        end
        if (!ovf && ln.size() == 0) begin
            n = 1; e0 = 1; e1 = 0;
        end else if (!ovf && ln.size() == 4 && ln[0] == 8'h50 && ln[1] == 8'h49 &&
                     ln[2] == 8'h4E && ln[3] == 8'h47) begin
            n = 2; e0 = 3; e1 = 1;
        end else begin
            n = 2; e0 = 2; e1 = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0]  q[$];
    logic [39:0] hb;
    logic [47:0] al;
    int          en, e0, e1;

    initial begin
        vt[0]  = '{320'({"PING", 8'h0D}), 5, 2, 3, 1};
        vt[1]  = '{320'({"PINGX", 8'h0D}), 6, 2, 2, 1};
        vt[2]  = '{320'({"ping", 8'h0D}), 5, 2, 2, 1};
        vt[3]  = '{320'({"PINX", 8'h08, "G", 8'h0A, 8'h0D}), 8, 2, 3, 1};
        vt[4]  = '{320'({{17{"A"}}, {3{8'h08}}, 8'h0D}), 21, 2, 2, 1};
        vt[5]  = '{320'(8'h0D), 1, 1, 1, 0};
        vt[6]  = '{320'({"PIN", 8'h7F, "NG", 8'h0D}), 7, 2, 3, 1};
        vt[7]  = '{320'({8'h08, "PING", 8'h0D}), 6, 2, 3, 1};
        vt[8]  = '{320'({{16{"X"}}, {16{8'h08}}, 8'h0D}), 33, 1, 1, 0};
        vt[9]  = '{320'({{17{"X"}}, {17{8'h08}}, 8'h0D}), 35, 2, 2, 1};
        vt[10] = '{320'({"ABCDEFGHIJKLMNOP", 8'h0D}), 17, 2, 2, 1};
        vt[11] = '{320'({"PIN", 8'h0D}), 4, 2, 2, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.valid", int'(msg_valid), 0);
        chk("reset.id", int'(msg_id), 0);
        chk("reset.busy", int'(busy), 1);
        rst = 1'b0;
        line_check("boot", 1'b0, 0, 2, 0, 1);

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vt[i].len; k++)
                send_byte(vt[i].b[8*(vt[i].len-1-k) +: 8]);
            line_check($sformatf("vec%0d", i), 1'b0, 1, vt[i].n, vt[i].e0, vt[i].e1);
        end

        // Stalled result: bytes strobed while busy must be dropped.
        hb = {"PING", 8'h0D};
        for (int k = 0; k < 5; k++) send_byte(hb[8*(4-k) +: 8]);
        msg_ready = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (msg_valid) break;
        end
        chk("hold.valid_seen", int'(msg_valid), 1);
        for (int k = 0; k < 10; k++) begin
            chk("hold.id", int'(msg_id), 3);
            chk("hold.busy", int'(busy), 1);
            chk("hold.valid", int'(msg_valid), 1);
            if (k < 5) begin
                rx_valid = 1'b1;
                rx_data  = hb[8*(4-k) +: 8];
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        line_check("hold.release", 1'b0, 0, 2, 3, 1);
        send_byte(8'h0D);
        line_check("hold.after", 1'b0, 1, 1, 1, 0);

        // Reset in the middle of a line.
        send_byte("P");
        send_byte("I");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.busy", int'(busy), 1);
        chk("rst.valid", int'(msg_valid), 0);
        rst = 1'b0;
        line_check("rst.boot", 1'b0, 0, 2, 0, 1);
        send_byte("N");
        send_byte("G");
        send_byte(8'h0D);
        line_check("rst.line", 1'b0, 1, 2, 2, 1);

        al = "PINGXp";
        for (int t = 0; t < 30; t++) begin
            q.delete();
            for (int k = 0; k < int'($urandom_range(0, 12)); k++) begin
                case ($urandom_range(0, 9))
                    0: begin
                        q.push_back(8'h50); q.push_back(8'h49);
                        q.push_back(8'h4E); q.push_back(8'h47);
                    end
                    1: q.push_back(8'h08);
                    2: q.push_back(8'h7F);
                    3: q.push_back(8'h0A);
                    default: q.push_back(al[8*$urandom_range(0, 5) +: 8]);
                endcase
            end
            q.push_back(8'h0D);
            model(q, en, e0, e1);
            foreach (q[k]) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send_byte(q[k]);
            end
            line_check($sformatf("rnd%0d", t), 1'b1, 0, en, e0, e1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
